// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
//   Holds one configuration word per pad. On request, it shifts all words
//   into the daisy-chained pad control blocks and then strobes serial_load.
//   The word for pad NUM_IO-1 goes out first and pad 0 last. Each word is
//   sent MSB first, so after the shift every block holds its own word.
//
// Ports
//   mclk, reset          system clock; synchronous active-high reset
//   cfg_we/addr/wdata    shadow word write (honoured only while idle)
//   cfg_rdata            combinational readback, 0 for addr >= NUM_IO
//   start                single-cycle load request
//   busy, done           sequence in progress / one-cycle completion pulse
//   wr_err               sticky: write attempted while busy
//   serial_resetn        registered chain reset
//   serial_clock/data/load  chain shift clock, data into pad 0, load strobe
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start (or the automatic load after reset)
// SHIFT     | CLK_DIV low / CLK_DIV high per bit, N bits total
// LOADGAP   | clock low, data held, CLK_DIV cycles before the strobe
// LOADPULSE | serial_load high for CLK_DIV cycles, then done
module gpio_serial_loader #(
  parameter int                       NUM_IO        = 8,
  parameter int                       PAD_CTRL_BITS = 12,
  parameter logic [PAD_CTRL_BITS-1:0] GPIO_DEFAULTS = 12'hC00,
  parameter int                       CLK_DIV       = 4,
  parameter bit                       AUTO_LOAD     = 1'b1,
  parameter int                       AW            = 3
) (
  input  logic                     mclk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0] cfg_wdata,
  output logic [PAD_CTRL_BITS-1:0] cfg_rdata,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     wr_err,
  output logic                     serial_resetn,
  output logic                     serial_clock,
  output logic                     serial_data,
  output logic                     serial_load
);

  localparam int BW    = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0] WORD_FIRST = AW'(NUM_IO - 1);
  localparam logic [BW-1:0] BIT_FIRST  = BW'(PAD_CTRL_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOADGAP, LOADPULSE} state_e;

  state_e                   state_q, state_d;
  logic [DW-1:0]            div_q, div_d;
  logic [AW-1:0]            word_q, word_d;
  logic [BW-1:0]            bitpos_q, bitpos_d;
  logic                     sclk_q, sclk_d;
  logic                     sdata_q, sdata_d;
  logic                     sload_q, sload_d;
  logic                     done_q, done_d;
  logic                     wr_err_q, wr_err_d;
  logic                     auto_q, auto_d;
  logic                     resetn_q;

  // Storage is sized to the full address space so cfg_addr indexes it
  // without width games. Entries at or above NUM_IO are never written and
  // never read back.
  logic [PAD_CTRL_BITS-1:0] shadow_q [DEPTH];
  logic [PAD_CTRL_BITS-1:0] shadow_d [DEPTH];

  logic addr_ok;
  logic idle;

  assign addr_ok = (32'(cfg_addr) < 32'(NUM_IO));
  assign idle    = (state_q == IDLE);

  assign cfg_rdata     = addr_ok ? shadow_q[cfg_addr] : '0;
  assign busy          = !idle;
  assign done          = done_q;
  assign wr_err        = wr_err_q;
  assign serial_resetn = resetn_q;
  assign serial_clock  = sclk_q;
  assign serial_data   = sdata_q;
  assign serial_load   = sload_q;

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we && idle && addr_ok) begin
      shadow_d[cfg_addr] = cfg_wdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    word_d   = word_q;
    bitpos_d = bitpos_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    sload_d  = sload_q;
    done_d   = 1'b0;
    wr_err_d = wr_err_q;
    auto_d   = auto_q;

    if (cfg_we && !idle) begin
      wr_err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          state_d  = SHIFT;
          auto_d   = 1'b0;
          wr_err_d = 1'b0;
          div_d    = DIV_LAST;
          word_d   = WORD_FIRST;
          bitpos_d = BIT_FIRST;
          sclk_d   = 1'b0;
          // Read through shadow_d so that a write in the start cycle is
          // reflected in the first bit.
          sdata_d  = shadow_d[WORD_FIRST][BIT_FIRST];
        end
      end

      SHIFT: begin
        if (div_q == '0) begin
          div_d = DIV_LAST;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: data advances in the same cycle as the clock drops.
            sclk_d = 1'b0;
            if (word_q == '0 && bitpos_q == '0) begin
              state_d = LOADGAP;
            end else begin
              if (bitpos_q == '0) begin
                word_d   = word_q - 1'b1;
                bitpos_d = BIT_FIRST;
              end else begin
                bitpos_d = bitpos_q - 1'b1;
              end
              sdata_d = shadow_q[word_d][bitpos_d];
            end
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      LOADGAP: begin
        if (div_q == '0) begin
          div_d   = DIV_LAST;
          sload_d = 1'b1;
          state_d = LOADPULSE;
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      LOADPULSE: begin
        if (div_q == '0) begin
          sload_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      word_q   <= '0;
      bitpos_q <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      sload_q  <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      auto_q   <= AUTO_LOAD;
      resetn_q <= 1'b0;
      shadow_q <= '{default: GPIO_DEFAULTS};
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      word_q   <= word_d;
      bitpos_q <= bitpos_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      sload_q  <= sload_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      auto_q   <= auto_d;
      resetn_q <= 1'b1;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader.
//   dut_a : NUM_IO=2, CLK_DIV=2, AUTO_LOAD=0, AW=3 (out-of-range address reachable)
//   dut_b : NUM_IO=2, CLK_DIV=1, AUTO_LOAD=1, AW=1
// Outputs are sampled on the falling edge of mclk, and inputs change there too.
// Cycle 0 is the cycle in which start is presented; the outputs seen at the
// falling edge c are the outputs of cycle c.
module tb_gpio_serial_loader;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- dut_a ----------------
  logic        reset_a = 1'b1, we_a = 1'b0, start_a = 1'b0;
  logic [2:0]  addr_a = '0;
  logic [11:0] wdata_a = '0, rdata_a;
  logic        busy_a, done_a, werr_a, rstn_a, sc_a, sd_a, sl_a;

  gpio_serial_loader #(.NUM_IO(2), .PAD_CTRL_BITS(12), .GPIO_DEFAULTS(12'hC00),
                       .CLK_DIV(2), .AUTO_LOAD(1'b0), .AW(3)) dut_a (
    .mclk(mclk), .reset(reset_a), .cfg_we(we_a), .cfg_addr(addr_a),
    .cfg_wdata(wdata_a), .cfg_rdata(rdata_a), .start(start_a), .busy(busy_a),
    .done(done_a), .wr_err(werr_a), .serial_resetn(rstn_a),
    .serial_clock(sc_a), .serial_data(sd_a), .serial_load(sl_a));

  // ---------------- dut_b ----------------
  logic        reset_b = 1'b1, we_b = 1'b0, start_b = 1'b0;
  logic [0:0]  addr_b = '0;
  logic [11:0] wdata_b = '0, rdata_b;
  logic        busy_b, done_b, werr_b, rstn_b, sc_b, sd_b, sl_b;

  gpio_serial_loader #(.NUM_IO(2), .PAD_CTRL_BITS(12), .GPIO_DEFAULTS(12'hC00),
                       .CLK_DIV(1), .AUTO_LOAD(1'b1), .AW(1)) dut_b (
    .mclk(mclk), .reset(reset_b), .cfg_we(we_b), .cfg_addr(addr_b),
    .cfg_wdata(wdata_b), .cfg_rdata(rdata_b), .start(start_b), .busy(busy_b),
    .done(done_b), .wr_err(werr_b), .serial_resetn(rstn_b),
    .serial_clock(sc_b), .serial_data(sd_b), .serial_load(sl_b));

  // Chain model: two 12-bit blocks. Data enters pad 0 and overflows into
  // pad 1. Each block latches on the rising edge of serial_load.
  int          nbits_a = 0, tog_a = 0, ovl_a = 0, dcnt_a = 0;
  logic [23:0] chain_a = '0;
  logic [11:0] lat0_a = '0, lat1_a = '0;
  logic        psc_a = 1'b0, psd_a = 1'b0, psl_a = 1'b0;

  always @(negedge mclk) begin
    if (sc_a && !psc_a) begin chain_a = {chain_a[22:0], sd_a}; nbits_a++; end
    if (sc_a && psc_a && (sd_a !== psd_a)) tog_a++;
    if (sc_a && sl_a) ovl_a++;
    if (sl_a && !psl_a) begin lat1_a = chain_a[23:12]; lat0_a = chain_a[11:0]; end
    if (done_a) dcnt_a++;
    psc_a = sc_a; psd_a = sd_a; psl_a = sl_a;
  end

  int          nbits_b = 0, tog_b = 0, ovl_b = 0, dcnt_b = 0;
  logic [23:0] chain_b = '0;
  logic [11:0] lat0_b = '0, lat1_b = '0;
  logic        psc_b = 1'b0, psd_b = 1'b0, psl_b = 1'b0;

  always @(negedge mclk) begin
    if (sc_b && !psc_b) begin chain_b = {chain_b[22:0], sd_b}; nbits_b++; end
    if (sc_b && psc_b && (sd_b !== psd_b)) tog_b++;
    if (sc_b && sl_b) ovl_b++;
    if (sl_b && !psl_b) begin lat1_b = chain_b[23:12]; lat0_b = chain_b[11:0]; end
    if (done_b) dcnt_b++;
    psc_b = sc_b; psd_b = sd_b; psl_b = sl_b;
  end

  // Timing observed by run_a / run_b
  logic r_busy1, r_werr1;
  int   r_busy_end, r_load_first, r_load_last, r_done_cyc;

  task automatic clear_a();
    nbits_a = 0; tog_a = 0; ovl_a = 0; dcnt_a = 0; chain_a = '0; lat0_a = '0; lat1_a = '0;
  endtask

  task automatic clear_b();
    nbits_b = 0; tog_b = 0; ovl_b = 0; dcnt_b = 0; chain_b = '0; lat0_b = '0; lat1_b = '0;
  endtask

  task automatic write_a(input logic [2:0] a, input logic [11:0] d);
    @(negedge mclk); we_a = 1'b1; addr_a = a; wdata_a = d;
    @(negedge mclk); we_a = 1'b0;
  endtask

  task automatic write_b(input logic [0:0] a, input logic [11:0] d);
    @(negedge mclk); we_b = 1'b1; addr_b = a; wdata_b = d;
    @(negedge mclk); we_b = 1'b0;
  endtask

  // A full load on dut_a (150 cycles). Optionally writes addr0=FFF in cycle
  // wr_cyc and pulses start in cycles st0/st1.
  task automatic run_a(input int wr_cyc, input int st0, input int st1);
    r_busy1 = 1'b0; r_werr1 = 1'b1;
    r_busy_end = -1; r_load_first = -1; r_load_last = -1; r_done_cyc = -1;
    clear_a();
    @(negedge mclk); start_a = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge mclk);
      start_a = (c == st0) || (c == st1);
      we_a    = (c == wr_cyc);
      addr_a  = 3'd0;
      wdata_a = 12'hFFF;
      if (c == 1) begin r_busy1 = busy_a; r_werr1 = werr_a; end
      if (!busy_a && r_busy_end < 0) r_busy_end = c;
      if (sl_a) begin if (r_load_first < 0) r_load_first = c; r_load_last = c; end
      if (done_a && r_done_cyc < 0) r_done_cyc = c;
    end
    start_a = 1'b0; we_a = 1'b0;
  endtask

  // A load on dut_b (80 cycles). Cycle 0 is either the start pulse or the
  // cycle in which reset is released.
  task automatic run_b(input bit use_reset);
    r_busy1 = 1'b0; r_werr1 = 1'b1;
    r_busy_end = -1; r_load_first = -1; r_load_last = -1; r_done_cyc = -1;
    clear_b();
    @(negedge mclk);
    if (use_reset) reset_b = 1'b0; else start_b = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge mclk);
      start_b = 1'b0;
      if (c == 1) begin r_busy1 = busy_b; r_werr1 = rstn_b; end
      if (!busy_b && r_busy_end < 0) r_busy_end = c;
      if (sl_b) begin if (r_load_first < 0) r_load_first = c; r_load_last = c; end
      if (done_b && r_done_cyc < 0) r_done_cyc = c;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge mclk);
    addr_a = 3'd1;
    #1;
    vectors++;
    if ({busy_a, done_a, werr_a, sc_a, sd_a, sl_a, rstn_a} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy/done/werr/sclk/sdata/sload/rstn=%b expected 0000000",
               {busy_a, done_a, werr_a, sc_a, sd_a, sl_a, rstn_a});
    end
    vectors++;
    if (rdata_a !== 12'hC00) begin
      miscompares++; $display("FAIL reset_shadow1: got %h expected c00", rdata_a);
    end
    reset_a = 1'b0;
    @(negedge mclk);
    vectors++;
    if (rstn_a !== 1'b1) begin
      miscompares++; $display("FAIL rstn_release: got %b expected 1", rstn_a);
    end
    repeat (5) @(negedge mclk);
    vectors++;
    if (busy_a !== 1'b0) begin
      miscompares++; $display("FAIL no_auto_load: busy got %b expected 0", busy_a);
    end
  endtask

  task automatic test_auto_load();
    run_b(1'b1);
    vectors++;
    if (r_busy1 !== 1'b1 || r_werr1 !== 1'b1) begin
      miscompares++; $display("FAIL auto_cycle1: busy=%b rstn=%b expected 1 1", r_busy1, r_werr1);
    end
    vectors++;
    if (r_done_cyc != 51 || dcnt_b != 1) begin
      miscompares++; $display("FAIL auto_done: cycle %0d count %0d expected 51 1", r_done_cyc, dcnt_b);
    end
    vectors++;
    if ({lat1_b, lat0_b} !== 24'hC00C00 || nbits_b != 24) begin
      miscompares++;
      $display("FAIL auto_chain: got %h bits %0d expected c00c00 bits 24", {lat1_b, lat0_b}, nbits_b);
    end
  endtask

  task automatic test_writes();
    write_a(3'd1, 12'hA5C);
    write_a(3'd0, 12'h3F1);
    write_a(3'd7, 12'h123);
    addr_a = 3'd1; #1;
    vectors++;
    if (rdata_a !== 12'hA5C) begin
      miscompares++; $display("FAIL rd_pad1: got %h expected a5c", rdata_a);
    end
    addr_a = 3'd0; #1;
    vectors++;
    if (rdata_a !== 12'h3F1) begin
      miscompares++; $display("FAIL rd_pad0: got %h expected 3f1", rdata_a);
    end
    addr_a = 3'd7; #1;
    vectors++;
    if (rdata_a !== 12'h000) begin
      miscompares++; $display("FAIL rd_oob: got %h expected 000", rdata_a);
    end
  endtask

  task automatic test_shift_load();
    run_a(-1, -1, -1);
    vectors++;
    if (r_busy1 !== 1'b1) begin
      miscompares++; $display("FAIL busy_cycle1: got %b expected 1", r_busy1);
    end
    vectors++;
    if (r_busy_end != 101) begin
      miscompares++; $display("FAIL busy_end: got cycle %0d expected 101", r_busy_end);
    end
    vectors++;
    if (r_load_first != 99 || r_load_last != 100) begin
      miscompares++;
      $display("FAIL load_window: got %0d..%0d expected 99..100", r_load_first, r_load_last);
    end
    vectors++;
    if (r_done_cyc != 101 || dcnt_a != 1) begin
      miscompares++; $display("FAIL done_pulse: cycle %0d count %0d expected 101 1", r_done_cyc, dcnt_a);
    end
    vectors++;
    if (lat1_a !== 12'hA5C || lat0_a !== 12'h3F1 || nbits_a != 24) begin
      miscompares++;
      $display("FAIL chain: pad1 %h pad0 %h bits %0d expected a5c 3f1 24", lat1_a, lat0_a, nbits_a);
    end
    vectors++;
    if (tog_a != 0 || ovl_a != 0) begin
      miscompares++; $display("FAIL clk_rules: high toggles %0d overlaps %0d expected 0 0", tog_a, ovl_a);
    end
  endtask

  task automatic test_back_to_back();
    run_a(20, 5, 50);
    vectors++;
    if (werr_a !== 1'b1) begin
      miscompares++; $display("FAIL wr_err_set: got %b expected 1", werr_a);
    end
    vectors++;
    if (dcnt_a != 1 || r_done_cyc != 101) begin
      miscompares++; $display("FAIL start_ignored: done count %0d cycle %0d expected 1 101", dcnt_a, r_done_cyc);
    end
    vectors++;
    if (lat1_a !== 12'hA5C || lat0_a !== 12'h3F1) begin
      miscompares++; $display("FAIL chain_busy_wr: pad1 %h pad0 %h expected a5c 3f1", lat1_a, lat0_a);
    end
    addr_a = 3'd0; #1;
    vectors++;
    if (rdata_a !== 12'h3F1) begin
      miscompares++; $display("FAIL shadow_busy_wr: got %h expected 3f1", rdata_a);
    end
    run_a(-1, -1, -1);
    vectors++;
    if (r_werr1 !== 1'b0) begin
      miscompares++; $display("FAIL wr_err_clear: got %b expected 0", r_werr1);
    end
  endtask

  task automatic test_reset_abort();
    logic [4:0] snap;
    snap = '1;
    clear_a();
    @(negedge mclk); start_a = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge mclk);
      start_a = 1'b0;
      if (c == 40) reset_a = 1'b1;
      if (c == 41) snap = {sc_a, sl_a, busy_a, rstn_a, done_a};
      if (c == 43) reset_a = 1'b0;
    end
    vectors++;
    if (snap !== 5'b0) begin
      miscompares++; $display("FAIL abort_state: sclk/sload/busy/rstn/done got %b expected 00000", snap);
    end
    repeat (120) @(negedge mclk);
    vectors++;
    if (dcnt_a != 0 || busy_a !== 1'b0) begin
      miscompares++; $display("FAIL abort_no_done: done count %0d busy %b expected 0 0", dcnt_a, busy_a);
    end
    addr_a = 3'd0; #1;
    vectors++;
    if (rdata_a !== 12'hC00) begin
      miscompares++; $display("FAIL abort_shadow0: got %h expected c00", rdata_a);
    end
    addr_a = 3'd1; #1;
    vectors++;
    if (rdata_a !== 12'hC00) begin
      miscompares++; $display("FAIL abort_shadow1: got %h expected c00", rdata_a);
    end
  endtask

  task automatic test_clk_div1();
    write_b(1'b1, 12'hA5C);
    write_b(1'b0, 12'h3F1);
    run_b(1'b0);
    vectors++;
    if (r_done_cyc != 51 || r_busy_end != 51 || dcnt_b != 1) begin
      miscompares++;
      $display("FAIL div1_done: cycle %0d busy_end %0d count %0d expected 51 51 1", r_done_cyc, r_busy_end, dcnt_b);
    end
    vectors++;
    if (r_load_first != 50 || r_load_last != 50) begin
      miscompares++; $display("FAIL div1_load: got %0d..%0d expected 50..50", r_load_first, r_load_last);
    end
    vectors++;
    if (lat1_b !== 12'hA5C || lat0_b !== 12'h3F1 || nbits_b != 24) begin
      miscompares++;
      $display("FAIL div1_chain: pad1 %h pad0 %h bits %0d expected a5c 3f1 24", lat1_b, lat0_b, nbits_b);
    end
    vectors++;
    if (tog_b != 0 || ovl_b != 0) begin
      miscompares++; $display("FAIL div1_clk_rules: toggles %0d overlaps %0d expected 0 0", tog_b, ovl_b);
    end
  endtask

  initial begin
    test_reset();
    test_auto_load();
    test_writes();
    test_shift_load();
    test_back_to_back();
    test_reset_abort();
    test_clk_div1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
